// File: rtl/median_window_gen.sv
// median_window_gen
//   Producer side of the median filter. It turns a raster pixel stream into 3x3
//   windows for the median sorter tree. Two line buffers hold the previous two
//   rows, and a 3x3 register array holds the three most recent columns.
//   Only fully interior windows are emitted. There is no border handling and no
//   backpressure.
module median_window_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid_i,
  input  logic [DATA_WIDTH-1:0]   in_data_i,
  input  logic                    in_sof_i,
  output logic                    out_valid_o,
  output logic [9*DATA_WIDTH-1:0] window_o,
  output logic                    out_sof_o
);

  // Counter widths. The floor of 1 keeps degenerate sizes legal.
  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);
  localparam logic [CW-1:0] COL_ONE  = CW'(1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);

  // Raster position counters. They point at the pixel expected next.
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  // Position of the pixel currently on the input. A start of frame overrides it.
  logic [CW-1:0] col_cur_s;
  logic [RW-1:0] row_cur_s;

  // Line buffer storage: lb1 holds row r-1 and lb2 holds row r-2.
  logic [DATA_WIDTH-1:0] lb1_q [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] lb2_q [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] lb1_rd_s;
  logic [DATA_WIDTH-1:0] lb2_rd_s;

  // 3x3 window array, element k = 3*y + x. y=0 is the oldest line and x=0 is
  // the oldest column.
  logic [DATA_WIDTH-1:0] win_q [9];
  logic [DATA_WIDTH-1:0] win_d [9];
  logic [9*DATA_WIDTH-1:0] win_packed_s;

  // Emission decode and registered outputs.
  logic                    emit_s;
  logic                    sof_hit_s;
  logic                    out_valid_q, out_valid_d;
  logic                    out_sof_q,   out_sof_d;
  logic [9*DATA_WIDTH-1:0] window_q,    window_d;

  // Resolve the current pixel position. An accepted start of frame forces (0,0).
  always_comb begin
    col_cur_s = col_q;
    row_cur_s = row_q;
    if (in_sof_i) begin
      col_cur_s = '0;
      row_cur_s = '0;
    end else begin
      col_cur_s = col_q;
      row_cur_s = row_q;
    end
  end

  // Advance the raster position on every accepted pixel. The last pixel of a
  // frame wraps to (0,0), which starts the next frame implicitly.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (in_valid_i) begin
      if (col_cur_s == COL_LAST) begin
        col_d = '0;
        if (row_cur_s == ROW_LAST) begin
          row_d = '0;
        end else begin
          row_d = row_cur_s + ROW_ONE;
        end
      end else begin
        col_d = col_cur_s + COL_ONE;
        row_d = row_cur_s;
      end
    end else begin
      col_d = col_q;
      row_d = row_q;
    end
  end

  // Read both line buffers at the current column before this cycle's write.
  always_comb begin
    lb1_rd_s = lb1_q[col_cur_s];
    lb2_rd_s = lb2_q[col_cur_s];
  end

  // Shift the window one column left and load the new right column from the
  // line buffers and the incoming pixel (top to bottom).
  always_comb begin
    for (int k = 0; k < 9; k++) begin
      win_d[k] = win_q[k];
    end
    if (in_valid_i) begin
      for (int y = 0; y < 3; y++) begin
        win_d[3*y]     = win_q[3*y + 1];
        win_d[3*y + 1] = win_q[3*y + 2];
      end
      win_d[2] = lb2_rd_s;
      win_d[5] = lb1_rd_s;
      win_d[8] = in_data_i;
    end else begin
      for (int k = 0; k < 9; k++) begin
        win_d[k] = win_q[k];
      end
    end
  end

  // Pack the post-shift window onto the flat bus that feeds the sorter.
  always_comb begin
    win_packed_s = '0;
    for (int k = 0; k < 9; k++) begin
      win_packed_s[DATA_WIDTH*k +: DATA_WIDTH] = win_d[k];
    end
  end

  // A pixel at row>=2 and col>=2 completes an interior window. Gating on the
  // column also keeps columns of the previous line out of the window.
  always_comb begin
    emit_s    = 1'b0;
    sof_hit_s = 1'b0;
    if (in_valid_i && (row_cur_s >= ROW_TWO) && (col_cur_s >= COL_TWO)) begin
      emit_s    = 1'b1;
      sof_hit_s = (row_cur_s == ROW_TWO) && (col_cur_s == COL_TWO);
    end else begin
      emit_s    = 1'b0;
      sof_hit_s = 1'b0;
    end
  end

  // Next state of the output stage. The window bus holds between pulses.
  always_comb begin
    out_valid_d = emit_s;
    out_sof_d   = sof_hit_s;
    window_d    = window_q;
    if (emit_s) begin
      window_d = win_packed_s;
    end else begin
      window_d = window_q;
    end
  end

  // Line buffer RAM. It has no reset because emission is gated until two
  // fresh rows have been written.
  always_ff @(posedge clk) begin
    if (in_valid_i) begin
      lb2_q[col_cur_s] <= lb1_rd_s;
      lb1_q[col_cur_s] <= in_data_i;
    end
  end

  // Raster position counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // 3x3 window register array.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 9; k++) begin
        win_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 9; k++) begin
        win_q[k] <= win_d[k];
      end
    end
  end

  // Registered output stage: single-cycle valid/sof pulse and held window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      window_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_sof_q   <= out_sof_d;
      window_q    <= window_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_sof_o   = out_sof_q;
  assign window_o    = window_q;

endmodule

// File: tb/tb_median_window_gen.sv
// Testbench for median_window_gen on a 4x4 image. A frame-image reference model
// derives every expected window directly from the pixel positions it tracks.
module tb_median_window_gen;

  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 4;

  logic            clk;
  logic            rst;
  logic            in_valid_i;
  logic [DW-1:0]   in_data_i;
  logic            in_sof_i;
  logic            out_valid_o;
  logic [9*DW-1:0] window_o;
  logic            out_sof_o;

  median_window_gen #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid_i (in_valid_i),
    .in_data_i  (in_data_i),
    .in_sof_i   (in_sof_i),
    .out_valid_o(out_valid_o),
    .window_o   (window_o),
    .out_sof_o  (out_sof_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: current frame image and the next pixel position.
  logic [DW-1:0]   img [H][W];
  int              mr;
  int              mc;
  logic [9*DW-1:0] last_win;

  int              n_checks;
  int              n_fail;
  int              n_win;
  int              n_sof;
  bit              first_seen;
  logic [9*DW-1:0] first_win;

  // Apply one input cycle, advance the model, and check the outputs on the
  // following falling edge.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic s);
    logic            exp_v;
    logic            exp_sof;
    logic [9*DW-1:0] exp_w;
    in_valid_i = v;
    in_data_i  = d;
    in_sof_i   = s;
    @(posedge clk);
    exp_v   = 1'b0;
    exp_sof = 1'b0;
    exp_w   = last_win;
    if (v) begin
      if (s) begin
        mr = 0;
        mc = 0;
      end
      img[mr][mc] = d;
      if (mr >= 2 && mc >= 2) begin
        exp_v   = 1'b1;
        exp_sof = (mr == 2 && mc == 2);
        for (int y = 0; y < 3; y++) begin
          for (int x = 0; x < 3; x++) begin
            exp_w[DW*(3*y+x) +: DW] = img[mr-2+y][mc-2+x];
          end
        end
        last_win = exp_w;
      end
      mc++;
      if (mc == W) begin
        mc = 0;
        mr++;
        if (mr == H) mr = 0;
      end
    end
    @(negedge clk);
    n_checks++;
    assert (out_valid_o === exp_v) else begin
      n_fail++;
      $error("FAIL out_valid observed=%0b expected=%0b", out_valid_o, exp_v);
    end
    n_checks++;
    assert (out_sof_o === exp_sof) else begin
      n_fail++;
      $error("FAIL out_sof observed=%0b expected=%0b", out_sof_o, exp_sof);
    end
    n_checks++;
    assert (window_o === exp_w) else begin
      n_fail++;
      $error("FAIL window observed=%h expected=%h", window_o, exp_w);
    end
    if (out_valid_o === 1'b1) begin
      n_win++;
      if (!first_seen) begin
        first_seen = 1'b1;
        first_win  = window_o;
      end
    end
    if (out_sof_o === 1'b1) n_sof++;
  endtask

  // Send npix pixels of a frame. mode 0: ramp base+4r+c, 1: random data,
  // 2: all 8'hFF except pixel (1,1) = 8'h00. idle_pct inserts random gaps,
  // during which a spurious sof is sometimes driven and must be ignored.
  task automatic send_pixels(input int npix, input int base, input bit sof_first,
                             input int idle_pct, input int mode);
    logic [DW-1:0] d;
    for (int i = 0; i < npix; i++) begin
      while (int'($urandom_range(99)) < idle_pct) begin
        step(1'b0, DW'($urandom), 1'($urandom_range(1)));
      end
      case (mode)
        0:       d = DW'(base + i);
        1:       d = DW'($urandom);
        2:       d = (i == 5) ? 8'h00 : 8'hFF;
        default: d = 8'h00;
      endcase
      step(1'b1, d, sof_first && (i == 0));
    end
  endtask

  task automatic begin_scenario();
    n_win      = 0;
    n_sof      = 0;
    first_seen = 1'b0;
    first_win  = '0;
  endtask

  task automatic check_count(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_vec(input string tag, input logic [9*DW-1:0] obs,
                           input logic [9*DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    n_checks++;
    assert (out_valid_o === 1'b0 && out_sof_o === 1'b0 && window_o === '0) else begin
      n_fail++;
      $error("FAIL %s observed=%0b/%0b/%h expected=0/0/0", tag, out_valid_o,
             out_sof_o, window_o);
    end
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    mr         = 0;
    mc         = 0;
    last_win   = '0;
    rst        = 1'b1;
    in_valid_i = 1'b0;
    in_data_i  = '0;
    in_sof_i   = 1'b0;
    begin_scenario();
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("reset_state");
    rst = 1'b0;

    // 1: one frame at full rate, ramp pixels.
    begin_scenario();
    send_pixels(16, 0, 1'b1, 0, 0);
    check_count("s1_windows", n_win, 4);
    check_count("s1_sofs", n_sof, 1);
    check_vec("s1_first_window", first_win, 72'h0A_09_08_06_05_04_02_01_00);
    step(1'b0, 8'h00, 1'b0);

    // 2: same frame with about 50% idle cycles.
    begin_scenario();
    send_pixels(16, 0, 1'b1, 50, 0);
    check_count("s2_windows", n_win, 4);
    check_vec("s2_first_window", first_win, 72'h0A_09_08_06_05_04_02_01_00);

    // 3: two back-to-back frames, sof only on the first.
    begin_scenario();
    send_pixels(16, 0, 1'b1, 0, 0);
    send_pixels(16, 0, 1'b0, 0, 0);
    check_count("s3_windows", n_win, 8);
    check_count("s3_sofs", n_sof, 2);

    // 4: sof reasserted at (2,1) starts a new frame with distinct pixels.
    begin_scenario();
    send_pixels(9, 0, 1'b1, 0, 0);
    send_pixels(16, 100, 1'b1, 0, 0);
    check_count("s4_windows", n_win, 4);
    check_vec("s4_first_window", first_win, 72'h6E_6D_6C_6A_69_68_66_65_64);

    // 5: reset pulsed at (3,0), then a full frame without sof.
    send_pixels(16, 0, 1'b1, 0, 0);
    send_pixels(12, 0, 1'b0, 0, 0);
    rst = 1'b1;
    #1;
    check_reset_outputs("s5_during_reset");
    @(negedge clk);
    check_reset_outputs("s5_reset_held");
    rst      = 1'b0;
    mr       = 0;
    mc       = 0;
    last_win = '0;
    begin_scenario();
    send_pixels(16, 0, 1'b0, 0, 0);
    check_count("s5_windows", n_win, 4);
    check_vec("s5_first_window", first_win, 72'h0A_09_08_06_05_04_02_01_00);

    // 6: all 8'hFF except the centre pixel of the first window.
    begin_scenario();
    send_pixels(16, 0, 1'b1, 0, 2);
    check_vec("s6_centre_window", first_win, 72'hFF_FF_FF_FF_00_FF_FF_FF_FF);

    // Random data frames with random gaps, sof on the first only.
    begin_scenario();
    send_pixels(16, 0, 1'b1, 30, 1);
    for (int f = 0; f < 5; f++) begin
      send_pixels(16, 0, 1'b0, 30, 1);
    end
    check_count("rand_windows", n_win, 24);
    check_count("rand_sofs", n_sof, 6);

    // Random mid-frame sof positions followed by a complete frame.
    for (int f = 0; f < 4; f++) begin
      send_pixels(int'($urandom_range(15)) + 1, 0, 1'b0, 20, 1);
      begin_scenario();
      send_pixels(16, 0, 1'b1, 20, 1);
      check_count("rand_abort_windows", n_win, 4);
    end

    repeat (3) step(1'b0, 8'h00, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
